// File: rtl/fast_pat_pkg.sv
// Shared types and sizing for the fast-pattern frame sequencer.
// Table geometry and the sequencer state encoding live here.
package fast_pat_pkg;

  localparam int TBL_DEPTH = 16;
  localparam int ADDR_W    = 13;
  localparam int IDX_W     = $clog2(TBL_DEPTH);
  localparam int LEN_W     = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_IDLE,
    TRIG,
    WAIT_BUSY,
    IN_FRAME,
    GAP,
    ADV
  } seq_state_e;

endpackage

// File: rtl/fast_pat_tbl.sv
// Pattern base-address table: one write port, one async read port.
// Contents are intentionally not reset.
module fast_pat_tbl
  import fast_pat_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [TBL_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fast_pat_sequencer.sv
// Frame scheduler: walks the pattern table, triggers the DMD timing
// generator and tracks its frame_busy handshake, gap and repeat count.
module fast_pat_sequencer
  import fast_pat_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_waddr,
  input  logic [ADDR_W-1:0] tbl_wdata,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic [15:0]       repeat_cnt,
  input  logic [15:0]       gap_cycles,
  input  logic              start,
  input  logic              stop,
  input  logic              frame_busy,
  output logic              frame_trig,
  output logic [ADDR_W-1:0] pat_base_addr,
  output logic [IDX_W-1:0]  pat_index,
  output logic              seq_active,
  output logic              seq_done,
  output logic              timeout_err,
  output logic [31:0]       frame_cnt
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(BUSY_TIMEOUT - 1);

  seq_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [LEN_W-1:0]  len_r;
  logic [15:0]       rep_r;
  logic [15:0]       gap_r;
  logic [15:0]       pass;
  logic [15:0]       gcnt;
  logic [TO_W-1:0]   to_cnt;
  logic              busy_q;
  logic              stop_pend;
  logic [ADDR_W-1:0] tbl_rdata;

  logic        stop_any;
  logic        busy_fall;
  logic        last_idx;
  logic        start_ok;
  logic [15:0] pass_nxt;

  fast_pat_tbl u_tbl (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (idx),
    .rdata (tbl_rdata)
  );

  assign stop_any  = stop | stop_pend;
  assign busy_fall = busy_q & ~frame_busy;
  assign last_idx  = ({1'b0, idx} == len_r - LEN_W'(1));
  assign pass_nxt  = pass + 16'd1;
  assign start_ok  = start & ~stop
                   & (seq_len != '0)
                   & (seq_len <= LEN_W'(TBL_DEPTH));
  assign seq_active = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      len_r         <= '0;
      rep_r         <= '0;
      gap_r         <= '0;
      pass          <= '0;
      gcnt          <= '0;
      to_cnt        <= '0;
      busy_q        <= 1'b0;
      stop_pend     <= 1'b0;
      frame_trig    <= 1'b0;
      pat_base_addr <= '0;
      pat_index     <= '0;
      seq_done      <= 1'b0;
      timeout_err   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      busy_q     <= frame_busy;
      frame_trig <= 1'b0;
      seq_done   <= 1'b0;
      if (state != IDLE && stop) stop_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start_ok) state <= LOAD;
        end
        LOAD: begin
          len_r       <= seq_len;
          rep_r       <= repeat_cnt;
          gap_r       <= gap_cycles;
          idx         <= '0;
          pass        <= '0;
          frame_cnt   <= '0;
          timeout_err <= 1'b0;
          state       <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (stop_any) begin
            state     <= IDLE;
            seq_done  <= 1'b1;
            stop_pend <= 1'b0;
          // both samples low: never trigger into a busy generator
          end else if (!frame_busy && !busy_q) begin
            pat_base_addr <= tbl_rdata;
            pat_index     <= idx;
            frame_trig    <= 1'b1;
            state         <= TRIG;
          end
        end
        TRIG: begin
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (frame_busy) begin
            state <= IN_FRAME;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            seq_done    <= 1'b1;
            stop_pend   <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        IN_FRAME: begin
          if (busy_fall) begin
            frame_cnt <= frame_cnt + 32'd1;
            if (stop_any) begin
              state     <= IDLE;
              seq_done  <= 1'b1;
              stop_pend <= 1'b0;
            end else if (gap_r == '0) begin
              state <= ADV;
            end else begin
              gcnt  <= gap_r;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gcnt == 16'd1) begin
            if (stop_any) begin
              state     <= IDLE;
              seq_done  <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              state <= ADV;
            end
          end else begin
            gcnt <= gcnt - 16'd1;
          end
        end
        ADV: begin
          if (last_idx) begin
            idx  <= '0;
            pass <= pass_nxt;
          end else begin
            idx <= idx + IDX_W'(1);
          end
          if (stop_any ||
              (last_idx && rep_r != '0 &&
               pass_nxt == rep_r)) begin
            state     <= IDLE;
            seq_done  <= 1'b1;
            stop_pend <= 1'b0;
          end else begin
            state <= WAIT_IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_pat_sequencer.sv
// Bench for fast_pat_sequencer: vector table, random runs against a
// queue-based schedule model, and hand-written corner sequences.
module tb_fast_pat_sequencer;
  import fast_pat_pkg::*;

  logic              clk;
  logic              rst;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_waddr;
  logic [ADDR_W-1:0] tbl_wdata;
  logic [LEN_W-1:0]  seq_len;
  logic [15:0]       repeat_cnt;
  logic [15:0]       gap_cycles;
  logic              start;
  logic              stop;
  logic              frame_busy;
  logic              frame_trig;
  logic [ADDR_W-1:0] pat_base_addr;
  logic [IDX_W-1:0]  pat_index;
  logic              seq_active;
  logic              seq_done;
  logic              timeout_err;
  logic [31:0]       frame_cnt;

  fast_pat_sequencer #(.BUSY_TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .tbl_we        (tbl_we),
    .tbl_waddr     (tbl_waddr),
    .tbl_wdata     (tbl_wdata),
    .seq_len       (seq_len),
    .repeat_cnt    (repeat_cnt),
    .gap_cycles    (gap_cycles),
    .start         (start),
    .stop          (stop),
    .frame_busy    (frame_busy),
    .frame_trig    (frame_trig),
    .pat_base_addr (pat_base_addr),
    .pat_index     (pat_index),
    .seq_active    (seq_active),
    .seq_done      (seq_done),
    .timeout_err   (timeout_err),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int rep;
    int gap;
    int dly;
    int hold;
    int frames;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_gen = -1000;
  int t_fall = 0;
  int t_start = 0;
  int last_trig = 0;
  int last_done = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int first_lat = 0;
  int space_viol = 0;
  int stab_viol = 0;
  int btrig_viol = 0;
  int exp_space = 3;
  bit gen_en = 1'b0;
  bit man_busy = 1'b0;
  int dly = 2;
  int hold = 20;

  logic [ADDR_W-1:0] tbl_m [TBL_DEPTH];
  logic [ADDR_W-1:0] got_addr [$];
  logic [IDX_W-1:0]  got_idx [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [IDX_W-1:0]  exp_idx [$];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // one clock; also plays the timing generator and logs triggers
  task automatic step();
    logic nb;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_trig) begin
      trig_cnt++;
      last_trig = cyc;
      got_addr.push_back(pat_base_addr);
      got_idx.push_back(pat_index);
      if (trig_cnt == 1) first_lat = cyc - t_start;
      else if (cyc - t_fall != exp_space) space_viol++;
      if (gen_en) t_gen = cyc;
    end
    if (seq_done) begin
      done_cnt++;
      last_done = cyc;
    end
    if (gen_en)
      nb = (cyc >= t_gen + dly) &&
           (cyc < t_gen + dly + hold);
    else
      nb = man_busy;
    if (frame_trig && nb) btrig_viol++;
    if (nb && got_addr.size() > 0 &&
        pat_base_addr !== got_addr[$])
      stab_viol++;
    if (frame_busy && !nb) t_fall = cyc;
    frame_busy = nb;
  endtask

  task automatic wr(int a, int d);
    tbl_we    = 1'b1;
    tbl_waddr = IDX_W'(a);
    tbl_wdata = ADDR_W'(d);
    tbl_m[a]  = ADDR_W'(d);
    step();
    tbl_we = 1'b0;
  endtask

  task automatic begin_run(int len, int rep, int gap);
    got_addr.delete();
    got_idx.delete();
    trig_cnt   = 0;
    done_cnt   = 0;
    space_viol = 0;
    stab_viol  = 0;
    btrig_viol = 0;
    first_lat  = 0;
    seq_len    = LEN_W'(len);
    repeat_cnt = 16'(rep);
    gap_cycles = 16'(gap);
    exp_space  = gap + 3;
    start      = 1'b1;
    t_start    = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_trigs(string nm, int cnt, int budget);
    int n = 0;
    while (trig_cnt < cnt && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_trig_seen"}, 64'(trig_cnt >= cnt), 64'd1);
  endtask

  // expected schedule: every pass walks entries 0..len-1
  task automatic build_exp(int len, int rep);
    exp_addr.delete();
    exp_idx.delete();
    for (int p = 0; p < rep; p++)
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(tbl_m[i]);
        exp_idx.push_back(IDX_W'(i));
      end
  endtask

  task automatic check_run(string nm, int frames);
    int mism = 0;
    chk({nm, "_trigs"}, 64'(trig_cnt), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i >= got_addr.size()) mism++;
      else if (got_addr[i] !== exp_addr[i] ||
               got_idx[i] !== exp_idx[i]) mism++;
    end
    chk({nm, "_addr_mism"}, 64'(mism), 64'd0);
    chk({nm, "_frame_cnt"}, 64'(frame_cnt), 64'(frames));
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({nm, "_first_lat"}, 64'(first_lat), 64'd3);
    chk({nm, "_space_viol"}, 64'(space_viol), 64'd0);
    chk({nm, "_stab_viol"}, 64'(stab_viol), 64'd0);
    chk({nm, "_busy_trig"}, 64'(btrig_viol), 64'd0);
    chk({nm, "_active"}, 64'(seq_active), 64'd0);
  endtask

  vec_t vecs [5];
  int   t0;
  int   r_rel;
  int   n;
  int   d0;

  initial begin
    vecs[0] = '{len: 3,  rep: 2, gap: 0, dly: 2, hold: 20, frames: 6};
    vecs[1] = '{len: 1,  rep: 3, gap: 4, dly: 1, hold: 1,  frames: 3};
    vecs[2] = '{len: 4,  rep: 1, gap: 2, dly: 3, hold: 5,  frames: 4};
    vecs[3] = '{len: 16, rep: 1, gap: 0, dly: 1, hold: 2,  frames: 16};
    vecs[4] = '{len: 2,  rep: 2, gap: 7, dly: 2, hold: 3,  frames: 4};

    rst = 1'b1;
    tbl_we = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    seq_len = '0;
    repeat_cnt = '0;
    gap_cycles = '0;
    start = 1'b0;
    stop = 1'b0;
    frame_busy = 1'b0;
    #1;
    chk("reset_outputs",
        64'({frame_trig, seq_active, seq_done, timeout_err,
             pat_base_addr, pat_index, frame_cnt}), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < TBL_DEPTH; i++) wr(i, i * 'h100);

    gen_en = 1'b1;
    foreach (vecs[v]) begin
      dly  = vecs[v].dly;
      hold = vecs[v].hold;
      build_exp(vecs[v].len, vecs[v].rep);
      begin_run(vecs[v].len, vecs[v].rep, vecs[v].gap);
      wait_done($sformatf("vec%0d", v), 5000);
      check_run($sformatf("vec%0d", v), vecs[v].frames);
      step();
    end

    for (int r = 0; r < 6; r++) begin
      int len;
      int rep;
      for (int k = 0; k < 4; k++)
        wr($urandom_range(0, 7), $urandom_range(0, 8191));
      len  = $urandom_range(1, 6);
      rep  = $urandom_range(1, 3);
      dly  = $urandom_range(1, 3);
      hold = $urandom_range(1, 8);
      build_exp(len, rep);
      begin_run(len, rep, $urandom_range(0, 6));
      wait_done($sformatf("rnd%0d", r), 5000);
      check_run($sformatf("rnd%0d", r), len * rep);
      step();
    end

    // stop mid-frame on the 4th frame of an endless loop
    dly  = 2;
    hold = 20;
    begin_run(1, 0, 10);
    wait_trigs("stop", 4, 500);
    for (int i = 0; i < 5; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done("stop", 200);
    chk("stop_frame_cnt", 64'(frame_cnt), 64'd4);
    chk("stop_done_lat", 64'(last_done - t_fall), 64'd1);
    for (int i = 0; i < 40; i++) step();
    chk("stop_no_5th", 64'(trig_cnt), 64'd4);
    chk("stop_done_cnt", 64'(done_cnt), 64'd1);
    chk("stop_active", 64'(seq_active), 64'd0);

    // generator never answers
    gen_en = 1'b0;
    man_busy = 1'b0;
    begin_run(1, 1, 0);
    wait_trigs("to", 1, 20);
    t0 = last_trig;
    n = 0;
    while (!timeout_err && n < 200) begin
      step();
      n++;
    end
    chk("to_lat", 64'(cyc - t0), 64'd65);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_done", 64'(seq_done), 64'd1);
    chk("to_active", 64'(seq_active), 64'd0);
    step();
    gen_en = 1'b1;
    dly  = 2;
    hold = 4;
    build_exp(1, 1);
    begin_run(1, 1, 0);
    step();
    chk("to_cleared", 64'(timeout_err), 64'd0);
    wait_done("to_rerun", 200);
    check_run("to_rerun", 1);

    // busy already high when the run starts
    gen_en = 1'b0;
    man_busy = 1'b1;
    step();
    step();
    begin_run(1, 1, 0);
    for (int i = 0; i < 50; i++) step();
    chk("bh_no_trig", 64'(trig_cnt), 64'd0);
    man_busy = 1'b0;
    step();
    r_rel = cyc;
    wait_trigs("bh", 1, 10);
    chk("bh_trig_lat", 64'(last_trig - r_rel), 64'd2);
    man_busy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    man_busy = 1'b0;
    wait_done("bh", 50);
    chk("bh_busy_trig", 64'(btrig_viol), 64'd0);
    chk("bh_frame_cnt", 64'(frame_cnt), 64'd1);

    // rewrite entry 1 while entry 0 is on screen
    gen_en = 1'b1;
    dly  = 2;
    hold = 20;
    wr(0, 'h0A0);
    wr(1, 'h055);
    begin_run(2, 1, 0);
    wait_trigs("ow", 1, 20);
    for (int i = 0; i < 4; i++) step();
    wr(1, 'h3C0);
    build_exp(2, 1);
    wait_done("ow", 200);
    check_run("ow", 2);

    // reset during a frame, then illegal starts
    begin_run(1, 0, 0);
    wait_trigs("rst", 1, 20);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs",
        64'({frame_trig, seq_active, seq_done, timeout_err,
             pat_base_addr, pat_index, frame_cnt}), 64'd0);
    gen_en = 1'b0;
    man_busy = 1'b0;
    got_addr.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    step();
    chk("rst_no_done", 64'(done_cnt), 64'(d0));
    begin_run(0, 1, 0);
    for (int i = 0; i < 5; i++) step();
    chk("len0_active", 64'(seq_active), 64'd0);
    chk("len0_trigs", 64'(trig_cnt), 64'd0);
    begin_run(17, 1, 0);
    for (int i = 0; i < 5; i++) step();
    chk("len17_active", 64'(seq_active), 64'd0);
    stop = 1'b1;
    begin_run(1, 1, 0);
    stop = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("startstop_active", 64'(seq_active), 64'd0);
    chk("startstop_trigs", 64'(trig_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
